// File: rtl/tt_pin_wb_bridge_if.sv
// ---------------------------------------------------------------------------
// tt_pin_wb_bridge_if
//
// Purpose: classic single-cycle Wishbone link between the TinyTapeout pin
// bridge (master) and the USB device core's register slave.
//
// Signals:
//   wb_CYC, wb_STB, wb_WE  master -> slave  cycle, strobe, write enable
//   wb_ADR[13:0]           master -> slave  word address
//   wb_SEL[3:0]            master -> slave  byte lane selects
//   wb_DAT_MOSI[31:0]      master -> slave  write data
//   wb_DAT_MISO[31:0]      slave -> master  read data
//   wb_ACK                 slave -> master  acknowledge
//
// Modports: master (the bridge), slave (the device core or a bench model).
// ---------------------------------------------------------------------------
interface tt_pin_wb_bridge_if;
   logic        wb_CYC;
   logic        wb_STB;
   logic        wb_WE;
   logic [13:0] wb_ADR;
   logic [3:0]  wb_SEL;
   logic [31:0] wb_DAT_MOSI;
   logic [31:0] wb_DAT_MISO;
   logic        wb_ACK;

   modport master (
      output wb_CYC, wb_STB, wb_WE, wb_ADR, wb_SEL, wb_DAT_MOSI,
      input  wb_DAT_MISO, wb_ACK
   );

   modport slave (
      input  wb_CYC, wb_STB, wb_WE, wb_ADR, wb_SEL, wb_DAT_MOSI,
      output wb_DAT_MISO, wb_ACK
   );
endinterface

// File: rtl/tt_pin_wb_bridge.sv
// ---------------------------------------------------------------------------
// tt_pin_wb_bridge
//
// Purpose: byte-serial host to Wishbone bridge. The host strobes command
// bytes in on the TinyTapeout pins; the bridge assembles address, byte
// selects and (for writes) a 32-bit data word, runs one classic Wishbone
// cycle, and for reads hands the returned word back one byte per strobe.
//
// Command byte sequence:
//   byte 0 : {we, x, adr[13:8]}
//   byte 1 : adr[7:0]
//   byte 2 : {xxxx, sel[3:0]}
//   byte 3..6 (writes only) : write data, least significant byte first
// Reads then return data bytes 0..3 on uo_out, advanced by each strobe.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   ena          TT enable; strobes ignored while low (bus cycle still ends)
//   ui_in[7:0]   host data byte
//   uo_out[7:0]  read byte in RDATA, else {5'b0, we, err, busy}
//   uio_in[7:0]  bit 4 = host strobe (asynchronous), other bits unused
//   uio_out[7:0] {err, done_tgl, busy, 1'b0, 4'b0}
//   uio_oe[7:0]  constant 8'b1110_0000
//   wb           Wishbone master modport
//
// Parameters:
//   TIMEOUT_W    width of the ACK timeout counter (timeout build only)
//
// Build option:
//   WB_TIMEOUT_EN  when defined, a bus cycle with no ACK for 2^TIMEOUT_W-1
//                  cycles is ended by the bridge, sets err and returns
//                  32'hFFFF_FFFF. When undefined, BUS waits for ACK forever
//                  and err stays 0.
// ---------------------------------------------------------------------------
module tt_pin_wb_bridge #(
   parameter int TIMEOUT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ena,
   input  logic [7:0]           ui_in,
   output logic [7:0]           uo_out,
   input  logic [7:0]           uio_in,
   output logic [7:0]           uio_out,
   output logic [7:0]           uio_oe,
   tt_pin_wb_bridge_if.master   wb
);

   typedef enum logic [2:0] {
      IDLE,
      ADRL,
      SELB,
      WDATA,
      BUS,
      RDATA
   } state_t;

   state_t      state;
   logic        sync1;
   logic        sync2;
   logic        sync3;
   logic        sync_v1;
   logic        sync_v2;
   logic        armed;
   logic        byte_stb;
   logic        byte_acc;
   logic        we_r;
   logic [13:0] adr_r;
   logic [3:0]  sel_r;
   logic [31:0] mosi_r;
   logic [31:0] miso_r;
   logic [1:0]  bidx;
   logic        cyc_r;
   logic        done_tgl;
   logic        err;
   logic        busy;
   logic        to_fire;
   logic        bus_done;
   logic        unused_uio;

   assign unused_uio = ^{uio_in[7:5], uio_in[3:0]};

   // Host strobe synchronizer and rising-edge detector. sync_v1/sync_v2
   // track how far a real pin sample has travelled since reset; the
   // detector is only armed once a genuine low has been seen, so a strobe
   // held high through reset release is not mistaken for a new byte.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= 1'b0;
         sync2   <= 1'b0;
         sync3   <= 1'b0;
         sync_v1 <= 1'b0;
         sync_v2 <= 1'b0;
         armed   <= 1'b0;
      end else begin
         sync1   <= uio_in[4];
         sync2   <= sync1;
         sync3   <= sync2;
         sync_v1 <= 1'b1;
         sync_v2 <= sync_v1;
         if (sync_v2 && !sync2)
            armed <= 1'b1;
      end
   end

   assign byte_stb = armed & sync2 & ~sync3;
   assign byte_acc = byte_stb & ena;

`ifdef WB_TIMEOUT_EN
   // The counter sits at zero outside BUS, so every bus cycle starts from
   // a cleared count. The cycle whose increment would reach all-ones ends
   // the transfer, which gives 2^TIMEOUT_W-1 cycles of CYC/STB.
   localparam logic [TIMEOUT_W-1:0] TO_LAST = {TIMEOUT_W{1'b1}} - 1'b1;

   logic [TIMEOUT_W-1:0] to_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         to_cnt <= '0;
      else if (state != BUS)
         to_cnt <= '0;
      else if (!wb.wb_ACK)
         to_cnt <= to_cnt + 1'b1;
   end

   assign to_fire = (state == BUS) && !wb.wb_ACK && (to_cnt == TO_LAST);
`else
   localparam int unused_timeout_w = TIMEOUT_W;

   assign to_fire = 1'b0;
`endif

   assign bus_done = (state == BUS) && (wb.wb_ACK || to_fire);

   // Command assembly and bus sequencing. CYC/STB are a single register
   // raised on the edge that accepts the final command byte, so address,
   // selects and write data are already stable when the slave sees STB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         we_r     <= 1'b0;
         adr_r    <= '0;
         sel_r    <= '0;
         mosi_r   <= '0;
         miso_r   <= '0;
         bidx     <= '0;
         cyc_r    <= 1'b0;
         done_tgl <= 1'b0;
         err      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (byte_acc) begin
                  we_r        <= ui_in[7];
                  adr_r[13:8] <= ui_in[5:0];
                  state       <= ADRL;
               end
            end
            ADRL: begin
               if (byte_acc) begin
                  adr_r[7:0] <= ui_in;
                  state      <= SELB;
               end
            end
            SELB: begin
               if (byte_acc) begin
                  sel_r <= ui_in[3:0];
                  err   <= 1'b0;
                  bidx  <= '0;
                  if (we_r) begin
                     state <= WDATA;
                  end else begin
                     state <= BUS;
                     cyc_r <= 1'b1;
                  end
               end
            end
            WDATA: begin
               if (byte_acc) begin
                  mosi_r[{bidx, 3'b000} +: 8] <= ui_in;
                  bidx <= bidx + 2'd1;
                  if (bidx == 2'd3) begin
                     state <= BUS;
                     cyc_r <= 1'b1;
                  end
               end
            end
            BUS: begin
               // Host strobes are deliberately not looked at here.
               if (bus_done) begin
                  cyc_r    <= 1'b0;
                  done_tgl <= ~done_tgl;
                  miso_r   <= wb.wb_ACK ? wb.wb_DAT_MISO : 32'hFFFF_FFFF;
                  bidx     <= '0;
                  if (to_fire)
                     err <= 1'b1;
                  state <= we_r ? IDLE : RDATA;
               end
            end
            RDATA: begin
               if (byte_acc) begin
                  bidx <= bidx + 2'd1;
                  if (bidx == 2'd3)
                     state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

   // Read data is presented byte by byte while in RDATA; elsewhere the
   // host sees a small status word.
   always_comb begin
      uo_out = {5'b0, we_r, err, busy};
      if (state == RDATA) begin
         case (bidx)
            2'd0:    uo_out = miso_r[7:0];
            2'd1:    uo_out = miso_r[15:8];
            2'd2:    uo_out = miso_r[23:16];
            default: uo_out = miso_r[31:24];
         endcase
      end
   end

   assign uio_out = {err, done_tgl, busy, 1'b0, 4'b0000};
   assign uio_oe  = 8'b1110_0000;

   assign wb.wb_CYC      = cyc_r;
   assign wb.wb_STB      = cyc_r;
   assign wb.wb_WE       = we_r;
   assign wb.wb_ADR      = adr_r;
   assign wb.wb_SEL      = sel_r;
   assign wb.wb_DAT_MOSI = mosi_r;

endmodule

// File: tb/tb_tt_pin_wb_bridge.sv
// ---------------------------------------------------------------------------
// tb_tt_pin_wb_bridge
//
// Purpose: self-checking bench for tt_pin_wb_bridge. A table of host
// commands (raw bytes in, expected bus fields and read data out) is
// replayed; expected bus cycles and read bytes are queued when a command
// is driven and popped when the bridge produces them. Hand-written
// sequences cover strobes during BUS, ena low, reset mid-cycle and, when
// WB_TIMEOUT_EN is defined, the ACK timeout.
// ---------------------------------------------------------------------------
module tb_tt_pin_wb_bridge;

   logic       clk;
   logic       rst;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   tt_pin_wb_bridge_if wb_bus ();

   tt_pin_wb_bridge #(.TIMEOUT_W(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uo_out  (uo_out),
      .uio_in  (uio_in),
      .uio_out (uio_out),
      .uio_oe  (uio_oe),
      .wb      (wb_bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got time limit reached, expected end of test");
      $fatal(1);
   end

   typedef struct {
      logic [55:0] bytes;
      int          nb;
      logic [31:0] rdata;
      int          ack_delay;
      logic        exp_we;
      logic [13:0] exp_adr;
      logic [3:0]  exp_sel;
      logic [31:0] exp_mosi;
      logic [31:0] exp_rd;
      logic [7:0]  exp_uo_end;
   } vec_t;

   typedef struct {
      logic        we;
      logic [13:0] adr;
      logic [3:0]  sel;
      logic [31:0] mosi;
   } bus_exp_t;

   bus_exp_t   exp_bus[$];
   logic [7:0] exp_rd[$];
   vec_t       vecs[5];
   int         tests_run = 0;
   int         tests_failed = 0;
   bit         found;
   int         cycles;
   logic       done_prev;
   logic       exp_done;

   // Compare one value and report it.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // One host byte: strobe low long enough to clear the synchronizer, then
   // high for three clocks so the third rising edge accepts it.
   task automatic sendByte(input logic [7:0] b);
      repeat (3) @(negedge clk);
      ui_in     = b;
      uio_in[4] = 1'b1;
      repeat (3) @(negedge clk);
      uio_in[4] = 1'b0;
   endtask

   task automatic pushBus(input logic we, input logic [13:0] adr, input logic [3:0] sel, input logic [31:0] mosi);
      bus_exp_t e;
      e.we   = we;
      e.adr  = adr;
      e.sel  = sel;
      e.mosi = mosi;
      exp_bus.push_back(e);
   endtask

   task automatic pushRead(input logic [31:0] word);
      for (int k = 0; k < 4; k++)
         exp_rd.push_back(word[8*k +: 8]);
   endtask

   task automatic waitForCyc(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (wb_bus.wb_CYC) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
   endtask

   // Slave side: check the cycle against the scoreboard, ACK after delay.
   task automatic serviceBus(input logic [31:0] rdata, input int delay);
      bit       seen;
      bus_exp_t e;
      int       len;
      waitForCyc(seen);
      checkOutput("bus_start", {31'b0, seen}, 32'd1);
      e = exp_bus.pop_front();
      if (seen) begin
         checkOutput("bus_stb", {31'b0, wb_bus.wb_STB}, 32'd1);
         checkOutput("bus_we", {31'b0, wb_bus.wb_WE}, {31'b0, e.we});
         checkOutput("bus_adr", {18'b0, wb_bus.wb_ADR}, {18'b0, e.adr});
         checkOutput("bus_sel", {28'b0, wb_bus.wb_SEL}, {28'b0, e.sel});
         if (e.we)
            checkOutput("bus_mosi", wb_bus.wb_DAT_MOSI, e.mosi);
         wb_bus.wb_DAT_MISO = rdata;
         len = 1;
         repeat (delay) begin
            @(negedge clk);
            if (wb_bus.wb_CYC)
               len++;
         end
         wb_bus.wb_ACK = 1'b1;
         @(negedge clk);
         wb_bus.wb_ACK = 1'b0;
         checkOutput("cyc_drop", {31'b0, wb_bus.wb_CYC}, 32'd0);
         checkOutput("cyc_len", len, delay + 1);
      end
   endtask

   task automatic readBytes();
      for (int k = 0; k < 4; k++) begin
         checkOutput($sformatf("rd_byte%0d", k), {24'b0, uo_out}, {24'b0, exp_rd.pop_front()});
         sendByte(8'h5A);
      end
      checkOutput("rd_idle_busy", {31'b0, uio_out[5]}, 32'd0);
   endtask

   task automatic applyStimulus(input int idx);
      vec_t v;
      logic dprev;
      logic dexp;
      v = vecs[idx];
      pushBus(v.exp_we, v.exp_adr, v.exp_sel, v.exp_mosi);
      if (!v.exp_we)
         pushRead(v.exp_rd);
      dprev = uio_out[6];
      for (int i = 0; i < v.nb; i++) begin
         sendByte(v.bytes[55 - 8*i -: 8]);
         if (i == 0)
            checkOutput("hdr_status", {24'b0, uo_out}, {27'b0, v.exp_we, 1'b0, 1'b1});
      end
      serviceBus(v.rdata, v.ack_delay);
      dexp = ~dprev;
      checkOutput("done_toggle", {31'b0, uio_out[6]}, {31'b0, dexp});
      if (!v.exp_we)
         readBytes();
      else
         checkOutput("wr_busy", {31'b0, uio_out[5]}, 32'd0);
      checkOutput("end_status", {24'b0, uo_out}, {24'b0, v.exp_uo_end});
   endtask

   initial begin
      vecs[0] = '{bytes: 56'h80_12_0F_78_56_34_12, nb: 7, rdata: 32'h0, ack_delay: 3,
                  exp_we: 1'b1, exp_adr: 14'h0012, exp_sel: 4'hF, exp_mosi: 32'h1234_5678,
                  exp_rd: 32'h0, exp_uo_end: 8'h04};
      vecs[1] = '{bytes: 56'h3F_FF_0F_00_00_00_00, nb: 3, rdata: 32'hDEAD_BEEF, ack_delay: 0,
                  exp_we: 1'b0, exp_adr: 14'h3FFF, exp_sel: 4'hF, exp_mosi: 32'h0,
                  exp_rd: 32'hDEAD_BEEF, exp_uo_end: 8'h00};
      vecs[2] = '{bytes: 56'hC1_A5_03_11_22_33_44, nb: 7, rdata: 32'h0, ack_delay: 1,
                  exp_we: 1'b1, exp_adr: 14'h01A5, exp_sel: 4'h3, exp_mosi: 32'h4433_2211,
                  exp_rd: 32'h0, exp_uo_end: 8'h04};
      vecs[3] = '{bytes: 56'h40_00_08_00_00_00_00, nb: 3, rdata: 32'h0055_AAFF, ack_delay: 2,
                  exp_we: 1'b0, exp_adr: 14'h0000, exp_sel: 4'h8, exp_mosi: 32'h0,
                  exp_rd: 32'h0055_AAFF, exp_uo_end: 8'h00};
      vecs[4] = '{bytes: 56'hBF_80_05_00_FF_00_FF, nb: 7, rdata: 32'h0, ack_delay: 0,
                  exp_we: 1'b1, exp_adr: 14'h3F80, exp_sel: 4'h5, exp_mosi: 32'hFF00_FF00,
                  exp_rd: 32'h0, exp_uo_end: 8'h04};

      rst                = 1'b1;
      ena                = 1'b1;
      ui_in              = 8'h00;
      uio_in             = 8'h00;
      wb_bus.wb_ACK      = 1'b0;
      wb_bus.wb_DAT_MISO = 32'h0;
      repeat (3) @(negedge clk);

      // Reset values.
      checkOutput("rst_uo_out", {24'b0, uo_out}, 32'h0);
      checkOutput("rst_uio_out", {24'b0, uio_out}, 32'h0);
      checkOutput("rst_uio_oe", {24'b0, uio_oe}, 32'hE0);
      checkOutput("rst_cyc", {31'b0, wb_bus.wb_CYC}, 32'd0);
      checkOutput("rst_stb", {31'b0, wb_bus.wb_STB}, 32'd0);
      checkOutput("rst_we", {31'b0, wb_bus.wb_WE}, 32'd0);
      checkOutput("rst_adr", {18'b0, wb_bus.wb_ADR}, 32'd0);
      checkOutput("rst_sel", {28'b0, wb_bus.wb_SEL}, 32'd0);
      checkOutput("rst_mosi", wb_bus.wb_DAT_MOSI, 32'd0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      for (int n = 0; n < 5; n++)
         applyStimulus(n);

      // Strobes while BUS is waiting are dropped; ena low cannot stall ACK.
      pushBus(1'b0, 14'h0010, 4'h1, 32'h0);
      pushRead(32'h8765_4321);
      done_prev = uio_out[6];
      sendByte(8'h00);
      sendByte(8'h10);
      sendByte(8'h01);
      waitForCyc(found);
      checkOutput("c_bus_start", {31'b0, found}, 32'd1);
      begin
         bus_exp_t e;
         e = exp_bus.pop_front();
         checkOutput("c_adr", {18'b0, wb_bus.wb_ADR}, {18'b0, e.adr});
         checkOutput("c_sel", {28'b0, wb_bus.wb_SEL}, {28'b0, e.sel});
         checkOutput("c_we", {31'b0, wb_bus.wb_WE}, {31'b0, e.we});
      end
      sendByte(8'hAA);
      sendByte(8'h55);
      checkOutput("c_cyc_held", {31'b0, wb_bus.wb_CYC}, 32'd1);
      ena                = 1'b0;
      wb_bus.wb_DAT_MISO = 32'h8765_4321;
      wb_bus.wb_ACK      = 1'b1;
      @(negedge clk);
      wb_bus.wb_ACK = 1'b0;
      checkOutput("c_cyc_drop", {31'b0, wb_bus.wb_CYC}, 32'd0);
      exp_done = ~done_prev;
      checkOutput("c_done", {31'b0, uio_out[6]}, {31'b0, exp_done});
      ena = 1'b1;
      readBytes();
      checkOutput("c_end", {24'b0, uo_out}, 32'h0);

      // ena low in IDLE: three strobes leave the state untouched.
      ena = 1'b0;
      sendByte(8'h80);
      sendByte(8'h00);
      sendByte(8'h0F);
      checkOutput("ena_busy", {31'b0, uio_out[5]}, 32'd0);
      ena = 1'b1;
      repeat (5) @(negedge clk);
      checkOutput("ena_lost", {31'b0, uio_out[5]}, 32'd0);

`ifdef WB_TIMEOUT_EN
      // Read with no ACK: 255 cycles of CYC, err set, all-ones data.
      done_prev = uio_out[6];
      pushRead(32'hFFFF_FFFF);
      sendByte(8'h00);
      sendByte(8'h01);
      sendByte(8'h0F);
      waitForCyc(found);
      checkOutput("to_start", {31'b0, found}, 32'd1);
      cycles = 0;
      while (wb_bus.wb_CYC && cycles < 600) begin
         cycles++;
         @(negedge clk);
      end
      checkOutput("to_len", cycles, 255);
      checkOutput("to_err", {31'b0, uio_out[7]}, 32'd1);
      exp_done = ~done_prev;
      checkOutput("to_done", {31'b0, uio_out[6]}, {31'b0, exp_done});
      readBytes();
      checkOutput("to_status", {24'b0, uo_out}, 32'h02);
      sendByte(8'h80);
      sendByte(8'h00);
      checkOutput("to_err_held", {31'b0, uio_out[7]}, 32'd1);
      sendByte(8'h0F);
      checkOutput("to_err_clr", {31'b0, uio_out[7]}, 32'd0);
      pushBus(1'b1, 14'h0000, 4'hF, 32'h0403_0201);
      sendByte(8'h01);
      sendByte(8'h02);
      sendByte(8'h03);
      sendByte(8'h04);
      serviceBus(32'h0, 0);
`endif

      // Reset during BUS, late ACK and strobe held across reset release.
      sendByte(8'h00);
      sendByte(8'h05);
      sendByte(8'h01);
      waitForCyc(found);
      checkOutput("rb_bus_start", {31'b0, found}, 32'd1);
      rst = 1'b1;
      #1;
      checkOutput("rb_cyc_async", {31'b0, wb_bus.wb_CYC}, 32'd0);
      checkOutput("rb_stb_async", {31'b0, wb_bus.wb_STB}, 32'd0);
      checkOutput("rb_uio_out", {24'b0, uio_out}, 32'h0);
      uio_in[4]     = 1'b1;
      wb_bus.wb_ACK = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) @(negedge clk);
      checkOutput("rb_no_byte", {31'b0, uio_out[5]}, 32'd0);
      checkOutput("rb_late_ack", {31'b0, wb_bus.wb_CYC}, 32'd0);
      checkOutput("rb_uo_out", {24'b0, uo_out}, 32'h0);
      uio_in[4]     = 1'b0;
      wb_bus.wb_ACK = 1'b0;
      sendByte(8'h80);
      checkOutput("rb_recover", {24'b0, uo_out}, 32'h05);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
